// File: rtl/ib_param.sv
// ib_param: switch input buffer holding packets in a circular FIFO and requesting the
// head packet's destination port, with overflow/bad-destination drop counting.
module ib_param #(
  parameter int PKTW     = 16,
  parameter int DEPTH    = 4,
  parameter int NPORT    = 4,
  parameter int AW       = 2,
  parameter int ADDR_LSB = 0,
  parameter int AFULL_TH = 3,
  parameter int BURST    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ack,
  input  logic [PKTW-1:0]            pkti,
  output logic [PKTW-1:0]            pkto,
  output logic                       full,
  output logic                       afull,
  output logic [NPORT-1:0]           req,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 drop_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nxt;
  logic [PKTW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp, rp1;
  logic [AW-1:0] dest, dest1;
  logic nonempty, dvalid, rel, bad, pop, push, ovf, hold;
  logic [NPORT-1:0] req_nxt;
  logic [9:0] dsum;
  assign rp1      = rp + PW'(1);
  assign dest     = mem[rp][ADDR_LSB+AW-1:ADDR_LSB];
  assign dest1    = mem[rp1][ADDR_LSB+AW-1:ADDR_LSB];
  assign nonempty = count != '0;
  assign dvalid   = 32'(dest) < NPORT;
  assign rel      = state == REQ && ack;
  assign bad      = state == IDLE && nonempty && !dvalid;
  assign pop      = rel || bad;
  assign push     = pkti[PKTW-1] && (count < CW'(DEPTH) || pop);
  assign ovf      = pkti[PKTW-1] && !push;
  // burst keeps the grant only when the packet behind the head is already stored
  assign hold     = BURST != 0 && count > CW'(1) && dest1 == dest;
  assign full     = count == CW'(DEPTH);
  assign afull    = count >= CW'(AFULL_TH);
  assign dsum     = 10'(drop_cnt) + 10'(ovf) + 10'(bad);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (nonempty && dvalid ? REQ : IDLE) : (ack && !hold ? IDLE : REQ);
  always_comb
    req_nxt = state_nxt == REQ ? (state == IDLE ? NPORT'(1) << dest : req) : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      req      <= '0;
      pkto     <= '0;
      drop_cnt <= '0;
    end else begin
      req      <= req_nxt;
      pkto     <= rel ? mem[rp] : '0;
      count    <= count + CW'(push) - CW'(pop);
      drop_cnt <= dsum > 10'd255 ? 8'hff : dsum[7:0];
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= pkti;
endmodule

// File: tb/tb_ib_param.sv
// tb_ib_param: directed checks of ib_param with a non-burst and a burst instance side by side.
module tb_ib_param;
  logic clk = 0, rst = 0, ack = 0;
  logic [15:0] pkti = '0, pkto0, pkto1;
  logic full0, full1, afull0, afull1;
  logic [3:0] req0, req1;
  logic [2:0] count0, count1;
  logic [7:0] drop0, drop1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  ib_param #(.AW(3), .BURST(0)) u0 (.clk(clk), .rst(rst), .ack(ack), .pkti(pkti), .pkto(pkto0),
    .full(full0), .afull(afull0), .req(req0), .count(count0), .drop_cnt(drop0));
  ib_param #(.AW(3), .BURST(1)) u1 (.clk(clk), .rst(rst), .ack(ack), .pkti(pkti), .pkto(pkto1),
    .full(full1), .afull(afull1), .req(req1), .count(count1), .drop_cnt(drop1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; ack = 0; pkti = '0;
    #3;
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req0 !== 4'b0) begin errors++; $display("FAIL reset_req: got %b want 0000", req0); end
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count0); end
    checks++; if (pkto0 !== 16'h0) begin errors++; $display("FAIL reset_pkto: got %h want 0000", pkto0); end
    checks++; if (drop0 !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop0); end
    checks++; if (full0 !== 1'b0 || afull0 !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%b afull=%b want 0 0", full0, afull0); end
  endtask

  task automatic test_single();
    do_reset();
    pkti = 16'h8012; tick(); pkti = '0;
    checks++; if (count0 !== 3'd1 || req0 !== 4'b0) begin errors++; $display("FAIL single_write: got count=%0d req=%b want 1 0000", count0, req0); end
    tick();
    checks++; if (req0 !== 4'b0100) begin errors++; $display("FAIL single_req: got %b want 0100", req0); end
    tick(); tick();
    checks++; if (req0 !== 4'b0100 || pkto0 !== 16'h0) begin errors++; $display("FAIL single_hold: got req=%b pkto=%h want 0100 0000", req0, pkto0); end
    ack = 1; tick(); ack = 0;
    checks++; if (pkto0 !== 16'h8012) begin errors++; $display("FAIL single_pkto: got %h want 8012", pkto0); end
    checks++; if (req0 !== 4'b0 || count0 !== 3'd0) begin errors++; $display("FAIL single_after: got req=%b count=%0d want 0000 0", req0, count0); end
    tick();
    checks++; if (pkto0 !== 16'h0) begin errors++; $display("FAIL single_pulse: got %h want 0000", pkto0); end
  endtask

  task automatic test_overflow();
    logic [15:0] p [5] = '{16'h8010, 16'h8021, 16'h8032, 16'h8043, 16'h8050};
    int n = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pkti = p[i]; tick();
      if (i == 1) begin checks++; if (afull0 !== 1'b0) begin errors++; $display("FAIL ovf_afull2: got %b want 0", afull0); end end
      if (i == 2) begin checks++; if (afull0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL ovf_afull3: got afull=%b full=%b want 1 0", afull0, full0); end end
      if (i == 3) begin checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full0); end end
    end
    pkti = '0;
    checks++; if (count0 !== 3'd4 || drop0 !== 8'd1) begin errors++; $display("FAIL ovf_drop: got count=%0d drop=%0d want 4 1", count0, drop0); end
    ack = 1;
    for (int c = 0; c < 12 && n < 4; c++) begin
      tick();
      if (pkto0 !== 16'h0) begin
        checks++; if (pkto0 !== p[n]) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", n, pkto0, p[n]); end
        n++;
      end
    end
    ack = 0;
    checks++; if (n !== 4 || count0 !== 3'd0) begin errors++; $display("FAIL ovf_drain: got %0d pkts count=%0d want 4 0", n, count0); end
  endtask

  task automatic test_bad_dest();
    logic seen = 0;
    do_reset();
    ack = 1;
    pkti = 16'h8005; tick(); pkti = '0;
    checks++; if (count0 !== 3'd1) begin errors++; $display("FAIL bad_write: got count=%0d want 1", count0); end
    for (int c = 0; c < 4; c++) begin
      tick();
      seen = seen | (req0 != 4'b0) | (pkto0 != 16'h0);
    end
    ack = 0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bad_req: got activity=%b want 0", seen); end
    checks++; if (count0 !== 3'd0 || drop0 !== 8'd1) begin errors++; $display("FAIL bad_drop: got count=%0d drop=%0d want 0 1", count0, drop0); end
  endtask

  task automatic test_burst();
    logic [15:0] pb [3] = '{16'h8001, 16'h8011, 16'h8021};
    logic [15:0] e0 [6] = '{16'h8001, 16'h0, 16'h8011, 16'h0, 16'h8021, 16'h0};
    logic [15:0] e1 [6] = '{16'h8001, 16'h8011, 16'h8021, 16'h0, 16'h0, 16'h0};
    logic [3:0]  r1 [6] = '{4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin pkti = pb[i]; tick(); end
    pkti = '0;
    checks++; if (req0 !== 4'b0010 || req1 !== 4'b0010) begin errors++; $display("FAIL burst_req: got %b %b want 0010 0010", req0, req1); end
    ack = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (pkto0 !== e0[c]) begin errors++; $display("FAIL nb_pkto%0d: got %h want %h", c, pkto0, e0[c]); end
      checks++; if (pkto1 !== e1[c] || req1 !== r1[c]) begin errors++; $display("FAIL burst_c%0d: got pkto=%h req=%b want %h %b", c, pkto1, req1, e1[c], r1[c]); end
    end
    ack = 0;
  endtask

  task automatic test_full_pushpop();
    logic [15:0] p [4] = '{16'h8010, 16'h8021, 16'h8032, 16'h8043};
    logic [15:0] d [4] = '{16'h8021, 16'h8032, 16'h8043, 16'h8050};
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin pkti = p[i]; tick(); end
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", full0); end
    ack = 1; pkti = 16'h8050; tick(); pkti = '0;
    checks++; if (pkto0 !== 16'h8010 || count0 !== 3'd4 || drop0 !== 8'd0) begin errors++; $display("FAIL pp_same: got pkto=%h count=%0d drop=%0d want 8010 4 0", pkto0, count0, drop0); end
    for (int c = 0; c < 12 && n < 4; c++) begin
      tick();
      if (pkto0 !== 16'h0) begin
        checks++; if (pkto0 !== d[n]) begin errors++; $display("FAIL pp_order%0d: got %h want %h", n, pkto0, d[n]); end
        n++;
      end
    end
    ack = 0;
    checks++; if (n !== 4) begin errors++; $display("FAIL pp_drain: got %0d pkts want 4", n); end
  endtask

  task automatic test_saturate();
    do_reset();
    pkti = 16'h8010;
    repeat (258) tick();
    checks++; if (drop0 !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", drop0); end
    repeat (2) tick();
    pkti = '0;
    checks++; if (drop0 !== 8'd255 || count0 !== 3'd4) begin errors++; $display("FAIL sat_255: got drop=%0d count=%0d want 255 4", drop0, count0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pkti = 16'h8001; tick();
    pkti = 16'h8011; tick();
    pkti = 16'h8021; tick();
    pkti = '0;
    checks++; if (req0 !== 4'b0010 || count0 !== 3'd3) begin errors++; $display("FAIL ar_pre: got req=%b count=%0d want 0010 3", req0, count0); end
    #2 rst = 0;
    #1;
    checks++; if (req0 !== 4'b0 || count0 !== 3'd0 || pkto0 !== 16'h0) begin errors++; $display("FAIL ar_clear: got req=%b count=%0d pkto=%h want 0000 0 0000", req0, count0, pkto0); end
    checks++; if (req1 !== 4'b0 || count1 !== 3'd0) begin errors++; $display("FAIL ar_clear1: got req=%b count=%0d want 0000 0", req1, count1); end
    rst = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_bad_dest();
    test_burst();
    test_full_pushpop();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
